// File: rtl/coco_pkg.sv
// coco_pkg: shared definitions for the CocoSketch op scheduler slice.
// Holds the element field layout, the element width and the scheduler FSM
// state encoding.
package coco_pkg;

    // Element layout: [31:0] increment, [63:32] key, [95:64] hash.
    localparam int ELEM_W   = 96;
    localparam int FIELD_W  = 32;
    localparam int INC_LSB  = 0;
    localparam int KEY_LSB  = 32;
    localparam int HASH_LSB = 64;

    typedef logic [ELEM_W-1:0] elem_t;

    // Scheduler FSM encoding, kept as plain constants for older tooling.
    localparam logic [1:0] ST_CLEAR = 2'd0;
    localparam logic [1:0] ST_RUN   = 2'd1;
    localparam logic [1:0] ST_DRAIN = 2'd2;

    // Increment field of an element.
    function automatic logic [FIELD_W-1:0] elem_inc(input elem_t e);
        return e[INC_LSB +: FIELD_W];
    endfunction

    // Key field of an element.
    function automatic logic [FIELD_W-1:0] elem_key(input elem_t e);
        return e[KEY_LSB +: FIELD_W];
    endfunction

endpackage : coco_pkg

// File: rtl/coco_op_scheduler_if.sv
// coco_op_scheduler_if: element input handshake, pipeline issue port,
// clear-sweep write port and statistics of the op scheduler.
// master = element source / observer side, slave = the scheduler.
interface coco_op_scheduler_if #(
    parameter int RAM_PTR = 10
);
    import coco_pkg::*;

    elem_t               in_hash_e_f;
    logic                in_valid;
    logic                in_ready;
    logic                start_clear;
    logic                clear_busy;
    elem_t               op_hash_e_f;
    logic                op_valid;
    logic                clr_wren;
    logic [RAM_PTR-1:0]  clr_addr;
    logic [31:0]         stat_issued;
    logic [31:0]         stat_stalls;

    modport master (
        output in_hash_e_f, in_valid, start_clear,
        input  in_ready, clear_busy, op_hash_e_f, op_valid,
               clr_wren, clr_addr, stat_issued, stat_stalls
    );

    modport slave (
        input  in_hash_e_f, in_valid, start_clear,
        output in_ready, clear_busy, op_hash_e_f, op_valid,
               clr_wren, clr_addr, stat_issued, stat_stalls
    );

endinterface : coco_op_scheduler_if

// File: rtl/coco_hazard_scoreboard.sv
// coco_hazard_scoreboard: PIPE_DEPTH-deep shift register of {valid, addr}
// tracking bucket addresses still inside the read-modify-write window.
// hit   : some valid entry holds query_addr.
// empty : no entry will be valid after the coming edge (nothing pushed and
//         only the oldest slot, if any, still occupied). The drain logic uses
//         this so the clear sweep starts in the first cycle the window is free.
module coco_hazard_scoreboard #(
    parameter int RAM_PTR    = 10,
    parameter int PIPE_DEPTH = 5
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               push,
    input  logic [RAM_PTR-1:0] push_addr,
    input  logic [RAM_PTR-1:0] query_addr,
    output logic               hit,
    output logic               empty
);

    logic [PIPE_DEPTH-1:0] slot_vld;
    logic [RAM_PTR-1:0]    slot_addr [PIPE_DEPTH];

    // Age valid bits by one slot per cycle; a push enters slot 0.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            slot_vld <= '0;
        end else begin
            slot_vld[0] <= push;
            for (int i = 1; i < PIPE_DEPTH; i++) begin
                slot_vld[i] <= slot_vld[i-1];
            end
        end
    end

    // Addresses travel alongside their valid bits; stale ones are masked.
    always_ff @(posedge clk) begin
        slot_addr[0] <= push_addr;
        for (int i = 1; i < PIPE_DEPTH; i++) begin
            slot_addr[i] <= slot_addr[i-1];
        end
    end

    // Parallel compare of the incoming address against every live slot.
    always_comb begin
        hit = 1'b0;
        for (int i = 0; i < PIPE_DEPTH; i++) begin
            if (slot_vld[i] && (slot_addr[i] == query_addr)) begin
                hit = 1'b1;
            end
        end
    end

    // Window is free after this edge when only the oldest slot may be live.
    always_comb begin
        empty = !push;
        for (int i = 0; i < PIPE_DEPTH - 1; i++) begin
            if (slot_vld[i]) begin
                empty = 1'b0;
            end
        end
    end

endmodule : coco_hazard_scoreboard

// File: rtl/coco_op_scheduler.sv
// coco_op_scheduler: issue controller in front of the CocoSketch bucket
// update pipeline. Accepts hashed elements, stalls any whose bucket address
// is still in the read-modify-write window, and sweeps the whole table to
// zero after reset and on start_clear (the RAMs are not reset).
// Optional build macro: SCHED_STATS_EN adds the stat_issued/stat_stalls
// counters; without it both outputs are tied to zero.
module coco_op_scheduler
    import coco_pkg::*;
#(
    parameter int RAM_PTR    = 10,
    parameter int HASH_BASE  = 0,
    parameter int PIPE_DEPTH = 5
) (
    input logic                clk,
    input logic                rst_n,
    coco_op_scheduler_if.slave bus
);

    localparam logic [RAM_PTR-1:0] CLR_LAST = '1;
    localparam logic [RAM_PTR-1:0] CLR_ONE  = {{(RAM_PTR-1){1'b0}}, 1'b1};

    logic [1:0]         state_q;
    logic [RAM_PTR-1:0] clr_addr_q;
    logic               clr_wren_q;

    elem_t              op_hash_p1;
    logic               vld_p1;

    logic [RAM_PTR-1:0] in_addr;
    logic               hit;
    logic               sb_empty;
    logic               is_run;
    logic               ready;
    logic               fire;

    // Bucket index sits HASH_BASE bits into the hash field.
    assign in_addr = bus.in_hash_e_f[HASH_LSB + HASH_BASE +: RAM_PTR];

    assign is_run = (state_q == ST_RUN);
    assign ready  = is_run && !hit;
    assign fire   = bus.in_valid && ready;

    coco_hazard_scoreboard #(
        .RAM_PTR    (RAM_PTR),
        .PIPE_DEPTH (PIPE_DEPTH)
    ) u_scoreboard (
        .clk        (clk),
        .rst_n      (rst_n),
        .push       (fire),
        .push_addr  (in_addr),
        .query_addr (in_addr),
        .hit        (hit),
        .empty      (sb_empty)
    );

    // Mode sequencing and the clear sweep. The write strobe is registered so
    // it is low while rst_n is held; the first post-reset cycle arms it.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= ST_CLEAR;
            clr_wren_q <= 1'b0;
            clr_addr_q <= '0;
        end else begin
            case (state_q)
                ST_CLEAR: begin
                    if (!clr_wren_q) begin
                        clr_wren_q <= 1'b1;
                    end else if (clr_addr_q == CLR_LAST) begin
                        clr_wren_q <= 1'b0;
                        clr_addr_q <= '0;
                        state_q    <= ST_RUN;
                    end else begin
                        clr_addr_q <= clr_addr_q + CLR_ONE;
                    end
                end
                ST_RUN: begin
                    if (bus.start_clear) begin
                        state_q <= ST_DRAIN;
                    end
                end
                ST_DRAIN: begin
                    if (sb_empty) begin
                        state_q    <= ST_CLEAR;
                        clr_wren_q <= 1'b1;
                        clr_addr_q <= '0;
                    end
                end
                default: begin
                    state_q    <= ST_CLEAR;
                    clr_wren_q <= 1'b0;
                    clr_addr_q <= '0;
                end
            endcase
        end
    end

    // Issue register: one element per cycle, one cycle after acceptance.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            vld_p1     <= 1'b0;
            op_hash_p1 <= '0;
        end else begin
            vld_p1 <= fire;
            if (fire) begin
                op_hash_p1 <= bus.in_hash_e_f;
            end
        end
    end

`ifdef SCHED_STATS_EN
    logic [31:0] issued_q;
    logic [31:0] stalls_q;

    // Free-running wrap-around counts of issues and conflict-stall cycles.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            issued_q <= '0;
            stalls_q <= '0;
        end else begin
            if (fire) begin
                issued_q <= issued_q + 32'd1;
            end
            if (is_run && bus.in_valid && hit) begin
                stalls_q <= stalls_q + 32'd1;
            end
        end
    end

    assign bus.stat_issued = issued_q;
    assign bus.stat_stalls = stalls_q;
`else
    assign bus.stat_issued = '0;
    assign bus.stat_stalls = '0;
`endif

    assign bus.in_ready    = ready;
    assign bus.clear_busy  = !is_run;
    assign bus.op_valid    = vld_p1;
    assign bus.op_hash_e_f = op_hash_p1;
    assign bus.clr_wren    = clr_wren_q;
    assign bus.clr_addr    = clr_addr_q;

endmodule : coco_op_scheduler

// File: tb/tb_coco_op_scheduler.sv
// tb_coco_op_scheduler: directed stimulus with a scoreboard queue. The driver
// pushes each accepted element with the cycle it must appear on op_valid;
// an independent monitor pops and compares whenever op_valid is high.
module tb_coco_op_scheduler;
    import coco_pkg::*;

    localparam int RAM_PTR    = 4;
    localparam int PIPE_DEPTH = 5;
    localparam int DEPTH      = 16;

`ifdef SCHED_STATS_EN
    localparam bit STATS_ON = 1'b1;
`else
    localparam bit STATS_ON = 1'b0;
`endif

    typedef struct {
        elem_t data;
        int    due;
    } exp_t;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    int   cyc = 0;
    int   errors = 0;
    int   checks = 0;
    exp_t exp_q[$];

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    coco_op_scheduler_if #(.RAM_PTR(RAM_PTR)) bus ();

    coco_op_scheduler #(
        .RAM_PTR    (RAM_PTR),
        .HASH_BASE  (0),
        .PIPE_DEPTH (PIPE_DEPTH)
    ) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    task automatic check(input string name, input logic [95:0] act, input logic [95:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s: got %0h required %0h (cycle %0d)", name, act, req, cyc);
        end
    endtask

    function automatic elem_t mk(input int addr, input int n);
        return {32'(addr), 32'hA000_0000 + 32'(n), 32'h0000_0100 + 32'(n)};
    endfunction

    // Monitor: pops expectations whenever the DUT issues.
    exp_t mon_e;
    always @(negedge clk) begin
        if (rst_n && bus.op_valid) begin
            if (exp_q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL op_unexpected: got %0h required no issue", bus.op_hash_e_f);
            end else begin
                mon_e = exp_q.pop_front();
                check("op_data", bus.op_hash_e_f, mon_e.data);
                check("op_cycle", 96'(cyc), 96'(mon_e.due));
            end
        end
        if (rst_n && bus.clr_wren) begin
            check("op_during_clear", bus.op_valid, 1'b0);
        end
    end

    // Present one element (from a negedge) until accepted or max_wait cycles.
    task automatic send(input elem_t d, input bit sc, input int max_wait, output int acc);
        exp_t e;
        bit   done;
        done = 1'b0;
        acc  = -1;
        bus.in_valid    = 1'b1;
        bus.in_hash_e_f = d;
        for (int w = 0; w < max_wait && !done; w++) begin
            #1;
            if (bus.in_ready) begin
                bus.start_clear = sc;
                e.data = d;
                e.due  = cyc + 1;
                exp_q.push_back(e);
                acc  = cyc;
                done = 1'b1;
            end
            @(negedge clk);
            bus.start_clear = 1'b0;
        end
        bus.in_valid = 1'b0;
        if (!done) begin
            checks++;
            errors++;
            $display("FAIL send_timeout: got no accept in %0d cycles required accept", max_wait);
        end
    endtask

    // Wait (bounded) for a clear sweep and check all DEPTH writes in order.
    task automatic sweep(input int max_wait, output int start);
        int w;
        w = 0;
        start = -1;
        while (!bus.clr_wren && w < max_wait) begin
            @(negedge clk);
            w++;
        end
        if (!bus.clr_wren) begin
            checks++;
            errors++;
            $display("FAIL clear_start_timeout: got clr_wren=0 required 1");
        end else begin
            start = cyc;
            for (int i = 0; i < DEPTH; i++) begin
                check("clr_wren", bus.clr_wren, 1'b1);
                check("clr_addr", bus.clr_addr, 96'(i));
                check("clear_busy", bus.clear_busy, 1'b1);
                check("in_ready_in_clear", bus.in_ready, 1'b0);
                @(negedge clk);
            end
            check("clr_wren_after", bus.clr_wren, 1'b0);
            check("clear_busy_after", bus.clear_busy, 1'b0);
            check("in_ready_after", bus.in_ready, 1'b1);
        end
    endtask

    task automatic idle(input int n);
        bus.in_valid = 1'b0;
        repeat (n) @(negedge clk);
    endtask

    task automatic check_stats(input int issued, input int stalls);
        check("stat_issued", bus.stat_issued, STATS_ON ? 96'(issued) : 96'd0);
        check("stat_stalls", bus.stat_stalls, STATS_ON ? 96'(stalls) : 96'd0);
    endtask

    task automatic check_reset_values();
        check("rst_in_ready", bus.in_ready, 1'b0);
        check("rst_clear_busy", bus.clear_busy, 1'b1);
        check("rst_op_valid", bus.op_valid, 1'b0);
        check("rst_op_hash", bus.op_hash_e_f, 96'd0);
        check("rst_clr_wren", bus.clr_wren, 1'b0);
        check("rst_clr_addr", bus.clr_addr, 96'd0);
        check("rst_stat_issued", bus.stat_issued, 96'd0);
        check("rst_stat_stalls", bus.stat_stalls, 96'd0);
    endtask

    int a[4];
    int t0, t1, s, w;

    initial begin
        bus.in_valid    = 1'b0;
        bus.in_hash_e_f = '0;
        bus.start_clear = 1'b0;
        rst_n = 1'b0;
        repeat (3) @(negedge clk);
        check_reset_values();
        rst_n = 1'b1;

        // Power-up sweep over 16 addresses.
        sweep(5, s);

        // Distinct addresses back-to-back: one issue per cycle, no stalls.
        for (int k = 0; k < 4; k++) begin
            send(mk(k + 1, k), 1'b0, 3, a[k]);
        end
        for (int k = 1; k < 4; k++) begin
            check("b2b_accept_gap", 96'(a[k] - a[0]), 96'(k));
        end
        idle(8);
        check_stats(4, 0);

        // Same address twice: second accepted PIPE_DEPTH+1 cycles later.
        send(mk(7, 10), 1'b0, 3, t0);
        send(mk(7, 11), 1'b0, 12, t1);
        check("same_addr_gap", 96'(t1 - t0), 96'd6);
        idle(8);
        check_stats(6, 5);

        // start_clear on an accepting cycle: element issued, drain, sweep.
        send(mk(3, 20), 1'b1, 3, t0);
        for (int j = 1; j <= 5; j++) begin
            check("drain_in_ready", bus.in_ready, 1'b0);
            check("drain_busy", bus.clear_busy, 1'b1);
            check("drain_clr_wren", bus.clr_wren, 1'b0);
            @(negedge clk);
        end
        sweep(2, s);
        check("drain_to_clear", 96'(s - t0), 96'd6);
        check_stats(7, 5);

        // Reset at clear address 9: reset values, then sweep from 0 again.
        rst_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        w = 0;
        while (!(bus.clr_wren && bus.clr_addr == 4'd9) && w < 30) begin
            @(negedge clk);
            w++;
        end
        check("reached_addr9", bus.clr_addr, 96'd9);
        rst_n = 1'b0;
        #1;
        check_reset_values();
        repeat (2) @(negedge clk);
        check_reset_values();
        rst_n = 1'b1;
        sweep(5, s);

        // Issue after the restarted sweep; counters restarted from zero.
        send(mk(5, 30), 1'b0, 3, t0);
        idle(8);
        check_stats(1, 0);

        check("scoreboard_drained", 96'(exp_q.size()), 96'd0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout required completion");
        $fatal(1, "watchdog");
    end

endmodule : tb_coco_op_scheduler
